// File: rtl/matrix_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_op_sequencer_if
//  Purpose  : Command/response handshake, datapath start/done and the
//             dimension configuration bus of the matrix-op sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface matrix_op_sequencer_if #(
    parameter int DIM_W  = 11,
    parameter int SIZE_W = 19,
    parameter int CNT_W  = 24
);
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [1:0]          i_cmd_mode;
    logic [2:0]          i_cmd_sec_lev;
    logic                o_rsp_valid;
    logic                i_rsp_ready;
    logic [1:0]          o_rsp_err;
    logic [CNT_W-1:0]    o_rsp_cycles;
    logic                o_start;
    logic                i_done;
    logic                o_abort;
    logic                o_busy;
    logic [1:0]          o_mode;
    logic [2:0]          o_sec_lev;
    logic [DIM_W:0]      o_a_rows;
    logic [DIM_W:0]      o_b_rows;
    logic [DIM_W-1:0]    o_a_rows_div_t;
    logic [DIM_W-1:0]    o_a_cols_div_t;
    logic [DIM_W-1:0]    o_b_rows_div_t;
    logic [DIM_W-1:0]    o_b_cols_div_t;
    logic [SIZE_W:0]     o_a_size_div_word_size;
    logic [SIZE_W:0]     o_b_size_div_word_size;
    logic [SIZE_W:0]     o_e_size_div_word_size;

    // Command issuer / datapath side
    modport master (
        output i_cmd_valid, i_cmd_mode, i_cmd_sec_lev, i_rsp_ready, i_done,
        input  o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_cycles, o_start,
               o_abort, o_busy, o_mode, o_sec_lev, o_a_rows, o_b_rows,
               o_a_rows_div_t, o_a_cols_div_t, o_b_rows_div_t, o_b_cols_div_t,
               o_a_size_div_word_size, o_b_size_div_word_size,
               o_e_size_div_word_size
    );

    // Sequencer side
    modport slave (
        input  i_cmd_valid, i_cmd_mode, i_cmd_sec_lev, i_rsp_ready, i_done,
        output o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_cycles, o_start,
               o_abort, o_busy, o_mode, o_sec_lev, o_a_rows, o_b_rows,
               o_a_rows_div_t, o_a_cols_div_t, o_b_rows_div_t, o_b_cols_div_t,
               o_a_size_div_word_size, o_b_size_div_word_size,
               o_e_size_div_word_size
    );
endinterface
`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_op_sequencer
//  Purpose  : Accepts one matrix-operation command, decodes the dimension
//             configuration for matrix_arithmetic, pulses start, waits for
//             done and returns a status response with the measured latency.
//  Options  : MATSEQ_TIMEOUT_EN - abort BUSY when the cycle counter saturates.
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_op_sequencer #(
    parameter int T      = 8,
    parameter int NBAR   = 8,
    parameter int DIM_W  = 11,
    parameter int SIZE_W = 19,
    parameter int CNT_W  = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    matrix_op_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Per-level constants; every division is folded at elaboration time
    localparam logic [DIM_W:0]    c_n_l1   = (DIM_W+1)'(640);
    localparam logic [DIM_W:0]    c_n_l3   = (DIM_W+1)'(976);
    localparam logic [DIM_W:0]    c_n_l5   = (DIM_W+1)'(1344);
    localparam logic [DIM_W:0]    c_nbar   = (DIM_W+1)'(NBAR);
    localparam logic [DIM_W-1:0]  c_ndt_l1 = (DIM_W)'(640 / T);
    localparam logic [DIM_W-1:0]  c_ndt_l3 = (DIM_W)'(976 / T);
    localparam logic [DIM_W-1:0]  c_ndt_l5 = (DIM_W)'(1344 / T);
    localparam logic [DIM_W-1:0]  c_one_dt = (DIM_W)'(1);
    localparam logic [SIZE_W:0]   c_nn_l1  = (SIZE_W+1)'(640 * 640 / T);
    localparam logic [SIZE_W:0]   c_nn_l3  = (SIZE_W+1)'(976 * 976 / T);
    localparam logic [SIZE_W:0]   c_nn_l5  = (SIZE_W+1)'(1344 * 1344 / T);
    localparam logic [SIZE_W:0]   c_nb_l1  = (SIZE_W+1)'(NBAR * 640 / T);
    localparam logic [SIZE_W:0]   c_nb_l3  = (SIZE_W+1)'(NBAR * 976 / T);
    localparam logic [SIZE_W:0]   c_nb_l5  = (SIZE_W+1)'(NBAR * 1344 / T);
    localparam logic [SIZE_W:0]   c_bb     = (SIZE_W+1)'(NBAR * NBAR / 8);
    localparam logic [CNT_W-1:0]  c_cnt_one = (CNT_W)'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_out_en;
    logic [1:0]         r_cmd_mode;
    logic [2:0]         r_cmd_lev;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_rsp_err;
    logic [CNT_W-1:0]   r_rsp_cycles;
    logic [1:0]         r_mode;
    logic [2:0]         r_sec_lev;
    logic [DIM_W:0]     r_a_rows, r_b_rows;
    logic [DIM_W-1:0]   r_ardt, r_acdt, r_brdt, r_bcdt;
    logic [SIZE_W:0]    r_as, r_bs, r_es;

    logic               w_cmd_ready, w_accept, w_cmd_ok, w_abort, w_cnt_sat;
    logic [DIM_W:0]     w_n, w_a_rows, w_b_rows;
    logic [DIM_W-1:0]   w_ndt, w_ardt, w_acdt, w_brdt, w_bcdt;
    logic [SIZE_W:0]    w_nn, w_nb, w_as, w_bs, w_es;

    // r_out_en keeps cmd_ready low for the cycle right after a reset edge
    assign w_cmd_ready = (r_state == S_IDLE) && r_out_en;
    assign w_accept    = bus.i_cmd_valid && w_cmd_ready;
    assign w_cmd_ok    = (bus.i_cmd_mode != 2'd3) &&
                         ((bus.i_cmd_sec_lev == 3'd1) ||
                          (bus.i_cmd_sec_lev == 3'd3) ||
                          (bus.i_cmd_sec_lev == 3'd5));
    assign w_cnt_sat   = (r_cnt == c_cnt_max);

    // Level lookup: N and its derived quotients (only legal levels reach LOAD)
    always_comb begin
        w_n   = c_n_l5;
        w_ndt = c_ndt_l5;
        w_nn  = c_nn_l5;
        w_nb  = c_nb_l5;
        case (r_cmd_lev)
            3'd1: begin w_n = c_n_l1; w_ndt = c_ndt_l1; w_nn = c_nn_l1; w_nb = c_nb_l1; end
            3'd3: begin w_n = c_n_l3; w_ndt = c_ndt_l3; w_nn = c_nn_l3; w_nb = c_nb_l3; end
            default: ;
        endcase
    end

    // Mode decode on top of the level lookup; defaults are the mode-1 shape
    always_comb begin
        w_a_rows = w_n;
        w_b_rows = c_nbar;
        w_ardt   = w_ndt;
        w_acdt   = w_ndt;
        w_brdt   = c_one_dt;
        w_bcdt   = w_ndt;
        w_as     = w_nn;
        w_bs     = w_nb;
        w_es     = w_nb;
        case (r_cmd_mode)
            2'd0: begin w_b_rows = w_n; w_brdt = w_ndt; w_bcdt = c_one_dt; end
            2'd2: begin w_acdt = c_one_dt; w_as = w_nb; w_es = c_bb; end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and the timeout abort strobe
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_cmd_ok ? S_LOAD : S_RESP;
            S_LOAD:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (bus.i_done) begin
                    w_state_nxt = S_RESP;
                end
`ifdef MATSEQ_TIMEOUT_EN
                else if (w_cnt_sat) begin
                    w_state_nxt = S_RESP;
                    w_abort     = 1'b1;
                end
`endif
            end
            S_RESP:  if (bus.i_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, configuration registers, latency counter and response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_en     <= 1'b0;
            r_cmd_mode   <= '0;
            r_cmd_lev    <= '0;
            r_cnt        <= '0;
            r_rsp_err    <= '0;
            r_rsp_cycles <= '0;
            r_mode       <= '0;
            r_sec_lev    <= '0;
            r_a_rows     <= '0;
            r_b_rows     <= '0;
            r_ardt       <= '0;
            r_acdt       <= '0;
            r_brdt       <= '0;
            r_bcdt       <= '0;
            r_as         <= '0;
            r_bs         <= '0;
            r_es         <= '0;
        end else begin
            r_out_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_mode <= bus.i_cmd_mode;
                        r_cmd_lev  <= bus.i_cmd_sec_lev;
                        if (!w_cmd_ok) r_rsp_err <= 2'd1;
                    end
                end
                S_LOAD: begin
                    r_mode    <= r_cmd_mode;
                    r_sec_lev <= r_cmd_lev;
                    r_a_rows  <= w_a_rows;
                    r_b_rows  <= w_b_rows;
                    r_ardt    <= w_ardt;
                    r_acdt    <= w_acdt;
                    r_brdt    <= w_brdt;
                    r_bcdt    <= w_bcdt;
                    r_as      <= w_as;
                    r_bs      <= w_bs;
                    r_es      <= w_es;
                end
                S_START: r_cnt <= '0;
                S_BUSY: begin
                    if (!w_cnt_sat) r_cnt <= r_cnt + c_cnt_one;
                    if (bus.i_done) begin
                        // Latency includes the done cycle; saturates with the counter
                        r_rsp_cycles <= w_cnt_sat ? r_cnt : (r_cnt + c_cnt_one);
                        r_rsp_err    <= 2'd0;
                    end else if (w_abort) begin
                        r_rsp_cycles <= c_cnt_max;
                        r_rsp_err    <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_cmd_ready            = w_cmd_ready;
    assign bus.o_rsp_valid            = (r_state == S_RESP);
    assign bus.o_rsp_err              = r_rsp_err;
    assign bus.o_rsp_cycles           = r_rsp_cycles;
    assign bus.o_start                = (r_state == S_START);
    assign bus.o_abort                = w_abort;
    assign bus.o_busy                 = (r_state == S_LOAD) || (r_state == S_START) ||
                                        (r_state == S_BUSY);
    assign bus.o_mode                 = r_mode;
    assign bus.o_sec_lev              = r_sec_lev;
    assign bus.o_a_rows               = r_a_rows;
    assign bus.o_b_rows               = r_b_rows;
    assign bus.o_a_rows_div_t         = r_ardt;
    assign bus.o_a_cols_div_t         = r_acdt;
    assign bus.o_b_rows_div_t         = r_brdt;
    assign bus.o_b_cols_div_t         = r_bcdt;
    assign bus.o_a_size_div_word_size = r_as;
    assign bus.o_b_size_div_word_size = r_bs;
    assign bus.o_e_size_div_word_size = r_es;
endmodule
`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_op_sequencer
//  Purpose  : Self-checking bench for matrix_op_sequencer: directed cases
//             plus randomized commands against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_op_sequencer;
`ifdef MATSEQ_TIMEOUT_EN
    localparam int TB_CNT_W = 6;
`else
    localparam int TB_CNT_W = 24;
`endif
    localparam int TB_T    = 8;
    localparam int TB_NBAR = 8;
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_cfg [11];
    int   m_err = 0;
    int   m_cyc = 0;

    matrix_op_sequencer_if #(.DIM_W(11), .SIZE_W(19), .CNT_W(TB_CNT_W)) bus ();

    matrix_op_sequencer #(
        .T(TB_T), .NBAR(TB_NBAR), .DIM_W(11), .SIZE_W(19), .CNT_W(TB_CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference configuration straight from the per-mode formulas
    function automatic void cfg_model(input int mode, input int lev);
        int n;
        n = (lev == 1) ? 640 : (lev == 3) ? 976 : 1344;
        m_cfg[0] = mode;
        m_cfg[1] = lev;
        m_cfg[2] = n;
        case (mode)
            0: begin
                m_cfg[3] = n;    m_cfg[4] = n/TB_T; m_cfg[5] = n/TB_T;
                m_cfg[6] = n/TB_T; m_cfg[7] = 1;
                m_cfg[8] = n*n/TB_T; m_cfg[9] = n*TB_NBAR/TB_T; m_cfg[10] = n*TB_NBAR/TB_T;
            end
            1: begin
                m_cfg[3] = TB_NBAR; m_cfg[4] = n/TB_T; m_cfg[5] = n/TB_T;
                m_cfg[6] = 1; m_cfg[7] = n/TB_T;
                m_cfg[8] = n*n/TB_T; m_cfg[9] = TB_NBAR*n/TB_T; m_cfg[10] = TB_NBAR*n/TB_T;
            end
            default: begin
                m_cfg[3] = TB_NBAR; m_cfg[4] = n/TB_T; m_cfg[5] = 1;
                m_cfg[6] = 1; m_cfg[7] = n/TB_T;
                m_cfg[8] = TB_NBAR*n/TB_T; m_cfg[9] = TB_NBAR*n/TB_T; m_cfg[10] = TB_NBAR*TB_NBAR/8;
            end
        endcase
    endfunction

    task automatic chk_cfg();
        chk("cfg_mode",    32'(bus.o_mode),                 m_cfg[0]);
        chk("cfg_sec_lev", 32'(bus.o_sec_lev),              m_cfg[1]);
        chk("cfg_a_rows",  32'(bus.o_a_rows),               m_cfg[2]);
        chk("cfg_b_rows",  32'(bus.o_b_rows),               m_cfg[3]);
        chk("cfg_a_rdt",   32'(bus.o_a_rows_div_t),         m_cfg[4]);
        chk("cfg_a_cdt",   32'(bus.o_a_cols_div_t),         m_cfg[5]);
        chk("cfg_b_rdt",   32'(bus.o_b_rows_div_t),         m_cfg[6]);
        chk("cfg_b_cdt",   32'(bus.o_b_cols_div_t),         m_cfg[7]);
        chk("cfg_a_size",  32'(bus.o_a_size_div_word_size), m_cfg[8]);
        chk("cfg_b_size",  32'(bus.o_b_size_div_word_size), m_cfg[9]);
        chk("cfg_e_size",  32'(bus.o_e_size_div_word_size), m_cfg[10]);
    endtask

    // One command end to end. delay < 0 means the datapath never answers.
    // Called and returns at a negedge with the sequencer idle.
    task automatic run_cmd(input int mode, input int lev, input int delay,
                           input int hold, input bit spur);
        bit legal;
        int start_cyc, rsp_cyc, n_start, n_abort, abort_cyc, limit, waitc, exp_rsp;
        legal = (mode != 3) && (lev == 1 || lev == 3 || lev == 5);
        waitc = 0;
        while (bus.o_cmd_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("cmd_ready_idle", 32'(bus.o_cmd_ready), 1);
        bus.i_cmd_valid   = 1'b1;
        bus.i_cmd_mode    = 2'(mode);
        bus.i_cmd_sec_lev = 3'(lev);
        bus.i_done        = spur;
        @(posedge clk); #1;
        bus.i_cmd_valid   = 1'b0;
        bus.i_cmd_mode    = 2'($urandom);
        bus.i_cmd_sec_lev = 3'($urandom);
        start_cyc = -1; rsp_cyc = -1; n_start = 0; n_abort = 0; abort_cyc = -1;
        limit = (delay < 0) ? CNT_MAX + 12 : delay + 12;
        for (int cyc = 1; cyc <= limit && rsp_cyc < 0; cyc++) begin
            if (cyc > 1) begin @(posedge clk); #1; end
            bus.i_done = (delay >= 0 && start_cyc >= 0 && cyc == start_cyc + delay) ||
                         (spur && cyc <= 2);
            @(negedge clk);
            if (bus.o_start === 1'b1) begin
                n_start++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (bus.o_abort === 1'b1) begin n_abort++; abort_cyc = cyc; end
            if (cyc == 1 && legal) chk("busy_load", 32'(bus.o_busy), 1);
            if (bus.o_rsp_valid === 1'b1) rsp_cyc = cyc;
        end
        bus.i_done = 1'b0;
        chk("rsp_seen", 32'(rsp_cyc >= 0), 1);
        if (legal) begin
            exp_rsp = (delay >= 0) ? delay + 3 : CNT_MAX + 4;
            m_err   = (delay >= 0) ? 0 : 2;
            m_cyc   = (delay >= 0 && delay < CNT_MAX) ? delay : CNT_MAX;
            cfg_model(mode, lev);
            chk("start_cycle", start_cyc, 2);
            chk("start_count", n_start, 1);
            chk("rsp_cycle",   rsp_cyc, exp_rsp);
            chk("abort_count", n_abort, (delay >= 0) ? 0 : 1);
            if (delay < 0) chk("abort_cycle", abort_cyc, exp_rsp - 1);
            chk("rsp_cycles",  32'(bus.o_rsp_cycles), m_cyc);
        end else begin
            m_err = 1;
            chk("illegal_rsp_cycle", rsp_cyc, 1);
            chk("illegal_no_start",  n_start, 0);
        end
        chk("rsp_err", 32'(bus.o_rsp_err), m_err);
        chk_cfg();
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(bus.o_rsp_valid), 1);
            chk("hold_ready", 32'(bus.o_cmd_ready), 0);
            chk("hold_err",   32'(bus.o_rsp_err), m_err);
            if (legal) chk("hold_cycles", 32'(bus.o_rsp_cycles), m_cyc);
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_drop",   32'(bus.o_rsp_valid), 0);
        chk("back_ready", 32'(bus.o_cmd_ready), 1);
    endtask

    int lev_r, mode_r, rsp_after;

    initial begin
        bus.i_cmd_valid   = 1'b0;
        bus.i_cmd_mode    = '0;
        bus.i_cmd_sec_lev = '0;
        bus.i_rsp_ready   = 1'b0;
        bus.i_done        = 1'b0;
        for (int i = 0; i < 11; i++) m_cfg[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_cmd_ready), 0);
        chk("rst_valid", 32'(bus.o_rsp_valid), 0);
        chk("rst_start", 32'(bus.o_start), 0);
        chk("rst_busy",  32'(bus.o_busy), 0);
        chk("rst_abort", 32'(bus.o_abort), 0);
        chk("rst_err",   32'(bus.o_rsp_err), 0);
        chk("rst_cyc",   32'(bus.o_rsp_cycles), 0);
        chk_cfg();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.o_cmd_ready), 1);

        // Directed cases
        run_cmd(2, 1, 5, 0, 1'b0);
`ifdef MATSEQ_TIMEOUT_EN
        run_cmd(0, 5, 40, 0, 1'b0);
`else
        run_cmd(0, 5, 100, 0, 1'b0);
`endif
        run_cmd(3, 1, 0, 20, 1'b0);
        run_cmd(0, 2, 0, 0, 1'b0);
        run_cmd(1, 3, 7, 20, 1'b1);
        run_cmd(1, 5, 1, 2, 1'b0);

        // Reset in the middle of BUSY
        bus.i_cmd_valid = 1'b1; bus.i_cmd_mode = 2'd0; bus.i_cmd_sec_lev = 3'd3;
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_rst", 32'(bus.o_busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) m_cfg[i] = 0;
        m_err = 0; m_cyc = 0;
        chk("mid_rst_ready", 32'(bus.o_cmd_ready), 0);
        chk("mid_rst_valid", 32'(bus.o_rsp_valid), 0);
        chk("mid_rst_busy",  32'(bus.o_busy), 0);
        chk("mid_rst_start", 32'(bus.o_start), 0);
        chk("mid_rst_abort", 32'(bus.o_abort), 0);
        chk("mid_rst_err",   32'(bus.o_rsp_err), 0);
        chk("mid_rst_cyc",   32'(bus.o_rsp_cycles), 0);
        chk_cfg();
        rsp_after = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            bus.i_done = (c == 2);
            @(negedge clk);
            if (bus.o_rsp_valid === 1'b1 || bus.o_start === 1'b1) rsp_after++;
            if (c == 0) chk("ready_after_mid_rst", 32'(bus.o_cmd_ready), 1);
        end
        bus.i_done = 1'b0;
        chk("no_rsp_after_rst", rsp_after, 0);
        run_cmd(2, 5, 9, 1, 1'b0);

`ifdef MATSEQ_TIMEOUT_EN
        // Counter saturates without done; then done on the saturating cycle wins
        run_cmd(0, 1, -1, 3, 1'b0);
        run_cmd(1, 3, CNT_MAX + 1, 0, 1'b0);
`endif

        // Randomized commands
        for (int k = 0; k < 30; k++) begin
            mode_r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       lev_r = 1;
                    1:       lev_r = 3;
                    default: lev_r = 5;
                endcase
            end else begin
                lev_r = $urandom_range(0, 7);
            end
            run_cmd(mode_r, lev_r, $urandom_range(1, 40), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
